inst_fetch_unit: RTL and testbench

Instruction fetch stage of the SRV1 core. It issues word reads to the instruction bus and buffers returned words in a small prefetch queue. It presents one instruction plus its PC per cycle to the decode stage; decode slices `inst[6:0]` into the opcode decoder. It handles PC redirection from jumps, branches and ECALL, including discarding a bus response that is already in flight.

---
 rtl/srv1_pkg.sv | 18 +
 rtl/fetch_queue.sv | 64 ++++++
 rtl/inst_fetch_unit.sv | 165 ++++++++++++++++
 tb/tb_inst_fetch_unit.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/srv1_pkg.sv
// Shared fetch-path types for the SRV1 core: FSM states, prefetch entry, NOP encoding.
// No logic here; imported by the fetch unit and its queue.
package srv1_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DROP  = 2'd2
    } fetch_state_t;

    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO of {word, pc}; head read straight from storage, so a push is visible the cycle after.
// Push is ignored when full unless a pop frees a slot in the same cycle; flush wins over push and pop.
module fetch_queue
    import srv1_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push_i,
    input  logic                    pop_i,
    input  logic                    flush_i,
    input  fetch_entry_t            wdata_i,
    output fetch_entry_t            rdata_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [$clog2(DEPTH):0]  count_o
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t    mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [AW:0]     count_q;
    logic            do_push;
    logic            do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign count_o = count_q;
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Storage needs no reset: the head is only consumed while count_q is non-zero.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/inst_fetch_unit.sv
// SRV1 fetch: one outstanding word read into a DEPTH-entry queue, ack-to-decode latency 1, stalls on full queue or bus_lock.
// SRV1_FETCH_MISALIGN_TRAP_EN adds fetch_fault for misaligned redirects; otherwise the low target bits are masked.
module inst_fetch_unit
    import srv1_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        bus_req,
    output logic [31:0] bus_addr,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    input  logic        bus_lock,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
`ifdef SRV1_FETCH_MISALIGN_TRAP_EN
   ,output logic        fetch_fault
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t  state_q;
    fetch_state_t  state_d;
    logic [31:0]   fetch_pc_q;
    logic [31:0]   fetch_pc_d;
    logic [31:0]   drop_addr_q;
    logic [31:0]   drop_addr_d;

    logic          q_push;
    logic          q_pop;
    logic          q_full;
    logic          q_empty;
    logic [CW-1:0] q_count;
    fetch_entry_t  q_wdata;
    fetch_entry_t  q_head;

    logic          fault_blk;
    logic          room_now;
    logic          room_after_push;
    logic [CW:0]   occ_after_push;
    logic          can_start;
    logic          can_continue;

    assign q_pop           = !q_empty && inst_ready;
    assign room_now        = !q_full || q_pop;
    assign occ_after_push  = {1'b0, q_count} + (CW+1)'(1) - (CW+1)'(q_pop);
    assign room_after_push = (occ_after_push < (CW+1)'(DEPTH));

    // can_start decides a request this cycle; can_continue decides one for the cycle after an ack.
    assign can_start    = room_now && !bus_lock && !redirect && !fault_blk && !rst;
    assign can_continue = room_after_push && !bus_lock && !redirect && !fault_blk;

    assign q_wdata = '{word: bus_rdata, pc: fetch_pc_q};

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        drop_addr_d = drop_addr_q;
        bus_req     = 1'b0;
        bus_addr    = fetch_pc_q;
        q_push      = 1'b0;

        case (state_q)
            IDLE: begin
                bus_req = can_start;
                if (can_start) begin
                    if (bus_ack) begin
                        q_push     = 1'b1;
                        fetch_pc_d = fetch_pc_q + 32'd4;
                        state_d    = can_continue ? FETCH : IDLE;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            FETCH: begin
                bus_req = 1'b1;
                if (bus_ack) begin
                    if (!redirect) begin
                        q_push     = 1'b1;
                        fetch_pc_d = fetch_pc_q + 32'd4;
                    end
                    state_d = can_continue ? FETCH : IDLE;
                end else if (redirect) begin
                    drop_addr_d = fetch_pc_q;
                    state_d     = DROP;
                end
            end
            DROP: begin
                // The abandoned request keeps its address until the bus acks it.
                bus_req  = 1'b1;
                bus_addr = drop_addr_q;
                if (bus_ack) begin
                    state_d = can_start ? FETCH : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (redirect) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            fetch_pc_q  <= RESET_PC;
            drop_addr_q <= RESET_PC;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            drop_addr_q <= drop_addr_d;
        end
    end

`ifdef SRV1_FETCH_MISALIGN_TRAP_EN
    logic fault_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_q <= 1'b0;
        end else if (redirect) begin
            fault_q <= (redirect_pc[1:0] != 2'b00);
        end
    end

    assign fetch_fault = fault_q;
    assign fault_blk   = fault_q;
`else
    logic unused_pc_lsb;

    assign unused_pc_lsb = ^redirect_pc[1:0];
    assign fault_blk     = 1'b0;
`endif

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk     (clk),
        .rst     (rst),
        .push_i  (q_push),
        .pop_i   (q_pop),
        .flush_i (redirect),
        .wdata_i (q_wdata),
        .rdata_o (q_head),
        .full_o  (q_full),
        .empty_o (q_empty),
        .count_o (q_count)
    );

    assign inst_valid = !q_empty;
    assign inst       = q_empty ? INST_NOP : q_head.word;
    assign inst_pc    = q_empty ? 32'h0 : q_head.pc;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: directed scenarios plus a randomized run against a queue-based reference model.
// The bus responder uses fixed or random ack latency and returns a hashed word per address.
module tb_inst_fetch_unit;
    import srv1_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int          DEPTH  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        bus_req;
    logic [31:0] bus_addr;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        bus_lock;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        fetch_fault;

    always #5 clk = ~clk;

    inst_fetch_unit #(
        .RESET_PC (RST_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus_req     (bus_req),
        .bus_addr    (bus_addr),
        .bus_ack     (bus_ack),
        .bus_rdata   (bus_rdata),
        .bus_lock    (bus_lock),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst        (inst),
        .inst_pc     (inst_pc)
`ifdef SRV1_FETCH_MISALIGN_TRAP_EN
       ,.fetch_fault (fetch_fault)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: expected queue contents as a list of PCs, next fetch address, drop/fault flags.
    logic [31:0] mq[$];
    logic [31:0] m_fpc;
    logic        m_drop;
    logic        m_fault;
    logic        prev_req, prev_ack, prev_lock;
    logic [31:0] prev_addr;

    int lat_mode;
    int lat;
    int wait_cnt;
    int ack_cnt = 0;
    int pop_cnt = 0;

    logic        s_req, s_valid, s_fault;
    logic [31:0] s_addr, s_pc, s_inst;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] memword(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_0000;
    endfunction

    task automatic do_reset();
        rst         = 1'b1;
        inst_ready  = 1'b0;
        bus_lock    = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        bus_ack     = 1'b0;
        bus_rdata   = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req", 32'(bus_req), 32'd0);
        check("rst_addr", bus_addr, RST_PC);
        check("rst_valid", 32'(inst_valid), 32'd0);
        check("rst_inst", inst, INST_NOP);
        check("rst_pc", inst_pc, 32'h0);
`ifdef SRV1_FETCH_MISALIGN_TRAP_EN
        check("rst_fault", 32'(fetch_fault), 32'd0);
`endif
        mq.delete();
        m_fpc     = RST_PC;
        m_drop    = 1'b0;
        m_fault   = 1'b0;
        prev_req  = 1'b0;
        prev_ack  = 1'b0;
        prev_lock = 1'b0;
        prev_addr = 32'h0;
        rst       = 1'b0;
    endtask

    // One clock cycle: drive inputs, answer the bus, check against the model, then advance.
    task automatic cycle(input logic rdy, input logic lck, input logic rd, input logic [31:0] rpc);
        logic pending, new_start, pop, accepted;
        inst_ready  = rdy;
        bus_lock    = lck;
        redirect    = rd;
        redirect_pc = rpc;
        bus_ack     = 1'b0;
        bus_rdata   = $urandom;
        #1;
        pending = prev_req && !prev_ack;
        if (bus_req) begin
            if (!pending) begin
                wait_cnt = 0;
                lat = (lat_mode < 0) ? int'($urandom_range(0, 3)) : lat_mode;
            end else begin
                wait_cnt++;
            end
            if (wait_cnt == lat) begin
                bus_ack   = 1'b1;
                bus_rdata = memword(bus_addr);
                ack_cnt++;
            end
        end
        #1;
        new_start = bus_req && !pending;
        pop       = inst_valid && inst_ready;
        s_req     = bus_req;
        s_addr    = bus_addr;
        s_valid   = inst_valid;
        s_pc      = inst_pc;
        s_inst    = inst;
        s_fault   = fetch_fault;

        check("valid", 32'(inst_valid), 32'(mq.size() > 0));
        if (inst_valid && mq.size() > 0) begin
            check("inst_pc", inst_pc, mq[0]);
            check("inst", inst, memword(mq[0]));
        end
        if (!inst_valid) check("nop", inst, INST_NOP);
        if (bus_req) check("align", 32'(bus_addr[1:0]), 32'd0);
        if (pending) begin
            check("req_hold", 32'(bus_req), 32'd1);
            check("addr_hold", bus_addr, prev_addr);
        end
        if (new_start) begin
            check("req_addr", bus_addr, m_fpc);
            check("room", 32'((mq.size() - int'(pop)) < DEPTH), 32'd1);
        end
        if (prev_lock && bus_lock) check("lock", 32'(new_start), 32'd0);
        if (redirect && !prev_req) check("redir_start", 32'(bus_req), 32'd0);
`ifdef SRV1_FETCH_MISALIGN_TRAP_EN
        check("fault", 32'(fetch_fault), 32'(m_fault));
        if (m_fault) check("fault_req", 32'(new_start), 32'd0);
`endif

        if (new_start) m_drop = 1'b0;
        if (bus_req && redirect) m_drop = 1'b1;
        accepted = bus_req && bus_ack && !m_drop;
        if (pop) pop_cnt++;
        if (redirect) begin
            mq.delete();
            m_fpc   = {rpc[31:2], 2'b00};
            m_fault = (rpc[1:0] != 2'b00);
        end else begin
            if (pop && mq.size() > 0) void'(mq.pop_front());
            if (accepted) begin
                mq.push_back(m_fpc);
                m_fpc = m_fpc + 32'd4;
            end
        end
        prev_req  = bus_req;
        prev_ack  = bus_ack;
        prev_addr = bus_addr;
        prev_lock = bus_lock;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          acks0;
        int          pops0;
        logic [31:0] rpc;

        // Zero-wait bus, decode always ready: one fetch and one instruction per cycle.
        lat_mode = 0;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 32'h0);
            check("t1_req", 32'(s_req), 32'd1);
            check("t1_addr", s_addr, 32'(4 * i));
            check("t1_valid", 32'(s_valid), 32'(i > 0));
            if (i > 0) check("t1_pc", s_pc, 32'(4 * (i - 1)));
        end

        // Decode stalled: queue fills with DEPTH words, then fetching resumes with the first pop.
        do_reset();
        acks0 = ack_cnt;
        repeat (5) cycle(1'b0, 1'b0, 1'b0, 32'h0);
        check("t2_acks", 32'(ack_cnt - acks0), 32'd2);
        check("t2_stall", 32'(s_req), 32'd0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check("t2_resume", 32'(s_req), 32'd1);
        check("t2_addr", s_addr, 32'd8);
        check("t2_pop_pc", s_pc, 32'd0);

        // Redirect while a slow request is in flight: old address held, data dropped.
        do_reset();
        lat_mode = 3;
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check("t3_addr0", s_addr, 32'h0);
        cycle(1'b1, 1'b0, 1'b1, 32'h100);
        check("t3_hold1", s_addr, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check("t3_hold2", s_addr, 32'h0);
        check("t3_noval", 32'(s_valid), 32'd0);
        acks0 = ack_cnt;
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check("t3_ack", 32'(ack_cnt - acks0), 32'd1);
        check("t3_hold3", s_addr, 32'h0);
        lat_mode = 0;
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check("t3_new_req", 32'(s_req), 32'd1);
        check("t3_new_addr", s_addr, 32'h100);
        check("t3_noval2", 32'(s_valid), 32'd0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check("t3_valid", 32'(s_valid), 32'd1);
        check("t3_pc", s_pc, 32'h100);
        check("t3_inst", s_inst, memword(32'h100));

        // Redirect, pop and ack in one cycle.
        do_reset();
        repeat (3) cycle(1'b1, 1'b0, 1'b0, 32'h0);
        acks0 = ack_cnt;
        cycle(1'b1, 1'b0, 1'b1, 32'h40);
        check("t4_pop", 32'(s_valid), 32'd1);
        check("t4_ack", 32'(ack_cnt - acks0), 32'd1);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check("t4_flush", 32'(s_valid), 32'd0);
        check("t4_addr", s_addr, 32'h40);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check("t4_pc", s_pc, 32'h40);

        // bus_lock while idle blocks fetch; lock during a request lets it finish.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 32'h0);
            check("t5_locked", 32'(s_req), 32'd0);
        end
        lat_mode = 2;
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        check("t5_start", 32'(s_req), 32'd1);
        acks0 = ack_cnt;
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        check("t5_keep", 32'(s_req), 32'd1);
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        check("t5_done", 32'(ack_cnt - acks0), 32'd1);
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        check("t5_blocked", 32'(s_req), 32'd0);
        lat_mode = 0;
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        check("t5_resume", 32'(s_req), 32'd1);
        check("t5_addr", s_addr, 32'h4);

        // Redirect right after reset blocks the first start; fetch_pc wraps at 2^32.
        do_reset();
        cycle(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
        check("t6_blocked", 32'(s_req), 32'd0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check("t6_top", s_addr, 32'hFFFF_FFFC);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check("t6_wrap", s_addr, 32'h0);
        check("t6_pc", s_pc, 32'hFFFF_FFFC);

`ifdef SRV1_FETCH_MISALIGN_TRAP_EN
        do_reset();
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 1'b1, 32'h102);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check("t7_fault", 32'(s_fault), 32'd1);
        check("t7_noreq", 32'(s_req), 32'd0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check("t7_noreq2", 32'(s_req), 32'd0);
        cycle(1'b1, 1'b0, 1'b1, 32'h200);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        check("t7_clear", 32'(s_fault), 32'd0);
        check("t7_req", 32'(s_req), 32'd1);
        check("t7_addr", s_addr, 32'h200);
`endif

        // Randomized traffic against the reference model.
        do_reset();
        lat_mode = -1;
        pops0 = pop_cnt;
        for (int i = 0; i < 3000; i++) begin
            rpc = $urandom_range(0, 32'h3FF);
`ifdef SRV1_FETCH_MISALIGN_TRAP_EN
            rpc[1:0] = 2'b00;
`endif
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                  $urandom_range(0, 24) == 0, rpc);
        end
        check("progress", 32'((pop_cnt - pops0) > 300), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
